// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb_if
//  Description : Bus bundle for regfile_sb.
//
//                - Decode/issue side: read addresses, read data and busy
//                  flags, plus load-issue busy marking.
//                - Writeback side: write address, raw data and extension
//                  mode.
//
//                Ports (master = core pipeline, slave = register file):
//                  ra       [NRD*AW]   read addresses, port k at ra[k*AW +: AW]
//                  rd       [NRD*XLEN] read data,     port k at rd[k*XLEN +: XLEN]
//                  rbusy    [NRD]      addressed register has a pending load
//                  wa       [AW]       write address
//                  wd       [XLEN]     raw write data, LSB-aligned
//                  we_mode  [3]        0 none, 1 full, 2 LB, 3 LH, 4 LBU,
//                                      5 LHU, 6 LW, 7 LWU
//                  set_busy [1]        load issued to set_addr
//                  set_addr [AW]       destination of the issued load
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic [2:0]          we_mode;
  logic                set_busy;
  logic [AW-1:0]       set_addr;

  modport master (
    output ra, wa, wd, we_mode, set_busy, set_addr,
    input  rd, rbusy
  );

  modport slave (
    input  ra, wa, wd, we_mode, set_busy, set_addr,
    output rd, rbusy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Parametrised integer register file with RV32/RV64 load-result
//                extension, optional same-cycle write-to-read bypass and a
//                per-register pending-load scoreboard. x0 reads as zero and is
//                never written or marked busy.
//
//                Ports:
//                  clk  - clock, rising edge
//                  rst  - asynchronous reset, active-low; clears all registers
//                         and all busy bits
//                  bus  - regfile_sb_if.slave (reads, write, busy marking)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic            w_we;
  logic            w_wr;
  logic [63:0]     w_wd64;
  logic [63:0]     w_ext64;
  logic [XLEN-1:0] w_wext;

  assign w_we = (bus.we_mode != 3'd0);
  assign w_wr = w_we && (bus.wa != '0);

  // Extension is computed at 64 bits and truncated, so the 32-bit modes
  // collapse to a plain copy when XLEN=32 without zero-width replications.
  assign w_wd64 = 64'(bus.wd);

  always_comb begin
    w_ext64 = '0;
    case (bus.we_mode)
      3'd1:    w_ext64 = w_wd64;
      3'd2:    w_ext64 = {{56{w_wd64[7]}},  w_wd64[7:0]};
      3'd3:    w_ext64 = {{48{w_wd64[15]}}, w_wd64[15:0]};
      3'd4:    w_ext64 = {56'd0, w_wd64[7:0]};
      3'd5:    w_ext64 = {48'd0, w_wd64[15:0]};
      3'd6:    w_ext64 = {{32{w_wd64[31]}}, w_wd64[31:0]};
      3'd7:    w_ext64 = {32'd0, w_wd64[31:0]};
      default: w_ext64 = '0;
    endcase
  end

  assign w_wext = w_ext64[XLEN-1:0];

  always_comb begin
    mem_d = mem_q;
    if (w_wr) begin
      mem_d[bus.wa] = w_wext;
    end
    mem_d[0] = '0;
  end

  // Clear first, then set: when both hit the same register the new load's
  // set must win over the writeback of the older load.
  always_comb begin
    busy_d = busy_q;
    if (w_wr) begin
      busy_d[bus.wa] = 1'b0;
    end
    if (bus.set_busy && (bus.set_addr != '0)) begin
      busy_d[bus.set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      mem_q  <= mem_d;
    end
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] w_ra;
      logic          w_hit;

      assign w_ra  = bus.ra[k*AW +: AW];
      // Forwarding is suppressed during reset so the outputs stay all-zero.
      assign w_hit = (BYPASS != 0) && rst && w_we && (bus.wa == w_ra);

      assign bus.rd[k*XLEN +: XLEN] = (w_ra == '0) ? '0
                                    : w_hit        ? w_wext
                                    :                mem_q[w_ra];

      // A write in flight to this register retires the pending load, so the
      // consumer can proceed in the same cycle it receives the bypassed data.
      assign bus.rbusy[k] = (w_ra != '0) && busy_q[w_ra] && !w_hit;
    end
  endgenerate
endmodule
`default_nettype wire
